fifo_to_ram_ctrl: RTL and testbench

FIFO_TO_RAM_CTRL -- requirements
Module: fifo_to_ram_ctrl

---
 rtl/fifo_to_ram_ctrl.sv | 136 +++++++++++++
 tb/tb_fifo_to_ram_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_to_ram_ctrl.sv
`timescale 1ns/1ps
// Purpose: drains NUM_WORDS words from a FIFO read port into RAM addresses 0..NUM_WORDS-1 per start pulse.
// Latency: one cycle from fifo_rdeq to the matching RAM write; sustains one word per cycle.
// Backpressure: fifo_rdempty stalls reads (in-flight word still lands); optional CHECKSUM_EN adds chk_sum.
module fifo_to_ram_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_WORDS = 16
) (
    input  logic              rvclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              fifo_rdempty,
    input  logic [DATA_W-1:0] fifo_out,
    output logic              fifo_rdeq,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              busy,
    output logic              done
`ifdef CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] chk_sum
`endif
);

    // One extra bit so the counters can hold NUM_WORDS == 2**ADDR_W.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [DATA_W-1:0] din_hold;

    // Read request: only while running, FIFO has data and words remain to fetch.
    always_comb begin
        fifo_rdeq = (state == RUN) && !fifo_rdempty && (rd_cnt < LAST);
    end

    // Control FSM with registered busy/done flags.
    always_ff @(posedge rvclk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rd_cnt <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= RUN;
                        rd_cnt <= '0;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (fifo_rdeq) begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                        if (rd_cnt == LAST - CNT_W'(1)) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Wait until the last in-flight word has been written.
                    if (wr_cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Write pipeline: the write strobe trails the read by one cycle; the
    // address is the read index, which equals wr_cnt since reads and writes stay in order.
    always_ff @(posedge rvclk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            din_hold <= '0;
            wr_cnt   <= '0;
        end else begin
            ram_we <= fifo_rdeq;
            if (fifo_rdeq) begin
                ram_addr <= rd_cnt[ADDR_W-1:0];
            end
            if (ram_we) begin
                din_hold <= fifo_out;
            end
            if (state == IDLE && start) begin
                wr_cnt <= '0;
            end else if (ram_we) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

    // FIFO data is only valid in the write cycle; outside it, present the last written word.
    always_comb begin
        ram_din = ram_we ? fifo_out : din_hold;
    end

`ifdef CHECKSUM_EN
    // Running modulo-2^DATA_W sum of every word written in the current transfer.
    always_ff @(posedge rvclk or negedge rst_n) begin
        if (!rst_n) begin
            chk_sum <= '0;
        end else if (state == IDLE && start) begin
            chk_sum <= '0;
        end else if (ram_we) begin
            chk_sum <= chk_sum + ram_din;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_to_ram_ctrl.sv
`timescale 1ns/1ps
// Testbench for fifo_to_ram_ctrl: FIFO model feeding a 16-word instance
// and a fixed-data NUM_WORDS=1 instance, write/done monitors, directed scenarios.
module tb_fifo_to_ram_ctrl;

    logic        rvclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        fifo_rdempty;
    logic [31:0] fifo_out = 32'h0;
    logic        fifo_rdeq;
    logic        ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_din;
    logic        busy;
    logic        done;

    logic        start1 = 1'b0;
    logic        fifo_rdeq1;
    logic        ram_we1;
    logic [4:0]  ram_addr1;
    logic [31:0] ram_din1;
    logic        busy1;
    logic        done1;
`ifdef CHECKSUM_EN
    logic [31:0] chk_sum;
    logic [31:0] chk_sum1;
    logic [31:0] chk_at_done = 32'h0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 rvclk = ~rvclk;

    fifo_to_ram_ctrl #(.DATA_W(32), .ADDR_W(5), .NUM_WORDS(16)) dut (
        .rvclk(rvclk), .rst_n(rst_n), .start(start),
        .fifo_rdempty(fifo_rdempty), .fifo_out(fifo_out),
        .fifo_rdeq(fifo_rdeq), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .busy(busy), .done(done)
`ifdef CHECKSUM_EN
        , .chk_sum(chk_sum)
`endif
    );

    fifo_to_ram_ctrl #(.DATA_W(32), .ADDR_W(5), .NUM_WORDS(1)) dut1 (
        .rvclk(rvclk), .rst_n(rst_n), .start(start1),
        .fifo_rdempty(1'b0), .fifo_out(32'hABCD0001),
        .fifo_rdeq(fifo_rdeq1), .ram_we(ram_we1), .ram_addr(ram_addr1),
        .ram_din(ram_din1), .busy(busy1), .done(done1)
`ifdef CHECKSUM_EN
        , .chk_sum(chk_sum1)
`endif
    );

    // FIFO model: show-behind read, data valid the cycle after fifo_rdeq.
    logic [31:0] mem [0:255];
    int wptr = 0;
    int rptr = 0;
    assign fifo_rdempty = (rptr == wptr) || stall;

    always @(posedge rvclk) begin
        if (fifo_rdeq) begin
            fifo_out <= mem[rptr];
            rptr     <= rptr + 1;
        end
    end

    // Monitors, sampled mid-cycle.
    int          cyc = 0;
    int          wcount = 0;
    logic [4:0]  w_addr [0:127];
    logic [31:0] w_dat  [0:127];
    int          w_cyc  [0:127];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          rdeq_cnt = 0;
    int          bad_rdeq = 0;
    int          w1_cnt = 0, w1_cyc = 0, rdeq1_cnt = 0, done1_cnt = 0, done1_cyc = 0;
    logic [4:0]  w1_addr = 5'h1f;
    logic [31:0] w1_dat = 32'h0;

    always @(negedge rvclk) begin
        if (ram_we && wcount < 128) begin
            w_addr[wcount] = ram_addr;
            w_dat[wcount]  = ram_din;
            w_cyc[wcount]  = cyc;
            wcount = wcount + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
`ifdef CHECKSUM_EN
            chk_at_done = chk_sum;
`endif
        end
        if (fifo_rdeq) rdeq_cnt = rdeq_cnt + 1;
        if (fifo_rdeq && fifo_rdempty) bad_rdeq = bad_rdeq + 1;
        if (ram_we1) begin
            w1_cnt  = w1_cnt + 1;
            w1_cyc  = cyc;
            w1_addr = ram_addr1;
            w1_dat  = ram_din1;
        end
        if (fifo_rdeq1) rdeq1_cnt = rdeq1_cnt + 1;
        if (done1) begin
            done1_cnt = done1_cnt + 1;
            done1_cyc = cyc;
        end
        cyc = cyc + 1;
    end

    task automatic load(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wptr] = first + 32'(i);
            wptr = wptr + 1;
        end
    endtask

    task automatic pulse_start();
        @(negedge rvclk);
        start = 1'b1;
        @(negedge rvclk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int prev, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge rvclk); #1;
            if (done_cnt > prev) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_writes(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge rvclk); #1;
            if (wcount >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({fifo_rdeq, ram_we, ram_addr, ram_din, busy, done} !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdeq=%b we=%b addr=%h din=%h busy=%b done=%b, required all 0",
                     fifo_rdeq, ram_we, ram_addr, ram_din, busy, done);
        end
        load(32'h1000, 16);
        repeat (3) @(negedge rvclk);
        rst_n = 1'b1;
        repeat (6) @(negedge rvclk);
        #1;
        checks++;
        if (busy !== 1'b0 || wcount !== 0 || rdeq_cnt !== 0) begin
            errors++;
            $display("FAIL reset_stays_idle: busy=%b writes=%0d rdeq=%0d, required 0/0/0", busy, wcount, rdeq_cnt);
        end
    endtask

    task automatic test_basic();
        int  base = wcount;
        int  d0 = done_cnt;
        int  r0 = rdeq_cnt;
        bit  ok;
        pulse_start();
        wait_done(d0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done_timeout: done never pulsed");
        end
        checks++;
        if (wcount - base !== 16 || rdeq_cnt - r0 !== 16) begin
            errors++;
            $display("FAIL basic_count: writes=%0d rdeq=%0d, required 16/16", wcount - base, rdeq_cnt - r0);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (w_addr[base+i] !== 5'(i) || w_dat[base+i] !== 32'h1000 + 32'(i)) begin
                errors++;
                $display("FAIL basic_word%0d: addr=%0d data=%h, required %0d/%h",
                         i, w_addr[base+i], w_dat[base+i], i, 32'h1000 + 32'(i));
            end
        end
        checks++;
        if (w_cyc[base+15] - w_cyc[base] !== 15) begin
            errors++;
            $display("FAIL basic_b2b: write span=%0d cycles, required 15", w_cyc[base+15] - w_cyc[base]);
        end
        checks++;
        if (done_cyc - w_cyc[base+15] !== 2) begin
            errors++;
            $display("FAIL basic_done_lat: done %0d cycles after last write, required 2", done_cyc - w_cyc[base+15]);
        end
        @(negedge rvclk); #1;
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== 5'd15 || ram_din !== 32'h100F || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: we=%b addr=%0d din=%h busy=%b done=%b, required 0/15/0000100f/0/0",
                     ram_we, ram_addr, ram_din, busy, done);
        end
    endtask

    task automatic test_stall();
        int base = wcount;
        int d0 = done_cnt;
        bit ok;
        load(32'h2000, 16);
        pulse_start();
        wait_writes(base + 5, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_wait_timeout: writes=%0d, required 5", wcount - base);
        end
        @(posedge rvclk); #1;
        stall = 1'b1;
        repeat (4) @(posedge rvclk);
        #1;
        stall = 1'b0;
        wait_done(d0, ok);
        checks++;
        if (!ok || wcount - base !== 16) begin
            errors++;
            $display("FAIL stall_count: done=%b writes=%0d, required 1/16", ok, wcount - base);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (w_addr[base+i] !== 5'(i) || w_dat[base+i] !== 32'h2000 + 32'(i)) begin
                errors++;
                $display("FAIL stall_word%0d: addr=%0d data=%h, required %0d/%h",
                         i, w_addr[base+i], w_dat[base+i], i, 32'h2000 + 32'(i));
            end
        end
        checks++;
        if (w_cyc[base+15] - w_cyc[base] !== 19) begin
            errors++;
            $display("FAIL stall_gap: write span=%0d cycles, required 19", w_cyc[base+15] - w_cyc[base]);
        end
    endtask

    task automatic test_start_ignored();
        int base = wcount;
        int d0 = done_cnt;
        bit ok;
        load(32'h3000, 16);
        pulse_start();
        repeat (4) @(negedge rvclk);
        pulse_start();
        wait_done(d0, ok);
        repeat (20) @(negedge rvclk);
        #1;
        checks++;
        if (!ok || wcount - base !== 16 || done_cnt - d0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: writes=%0d dones=%0d busy=%b, required 16/1/0",
                     wcount - base, done_cnt - d0, busy);
        end
    endtask

    task automatic test_checksum();
        int          base = wcount;
        int          d0 = done_cnt;
        bit          ok;
        logic [31:0] sum = 32'h0;
        load(32'h1, 16);
        pulse_start();
        wait_done(d0, ok);
        for (int i = 0; i < 16; i++) sum = sum + w_dat[base+i];
        checks++;
        if (!ok || sum !== 32'd136) begin
            errors++;
            $display("FAIL data_sum: sum of written words=%0d, required 136", sum);
        end
`ifdef CHECKSUM_EN
        checks++;
        if (chk_at_done !== 32'h88) begin
            errors++;
            $display("FAIL chk_sum: at done=%h, required 00000088", chk_at_done);
        end
`endif
    endtask

    task automatic test_single();
        int d0 = done1_cnt;
        @(negedge rvclk);
        start1 = 1'b1;
        @(negedge rvclk);
        start1 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge rvclk); #1;
            if (done1_cnt > d0) break;
        end
        repeat (5) @(negedge rvclk);
        #1;
        checks++;
        if (rdeq1_cnt !== 1 || w1_cnt !== 1 || w1_addr !== 5'd0 || w1_dat !== 32'hABCD0001) begin
            errors++;
            $display("FAIL single_write: rdeq=%0d writes=%0d addr=%0d data=%h, required 1/1/0/abcd0001",
                     rdeq1_cnt, w1_cnt, w1_addr, w1_dat);
        end
        checks++;
        if (done1_cnt - d0 !== 1 || done1_cyc - w1_cyc !== 2) begin
            errors++;
            $display("FAIL single_done: dones=%0d lat=%0d, required 1/2", done1_cnt - d0, done1_cyc - w1_cyc);
        end
    endtask

    task automatic test_reset_mid();
        int base = wcount;
        int snap;
        bit ok;
        load(32'h4000, 16);
        pulse_start();
        wait_writes(base + 8, ok);
        @(posedge rvclk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || {fifo_rdeq, ram_we, ram_addr, ram_din, busy, done} !== 40'h0) begin
            errors++;
            $display("FAIL midreset_outputs: rdeq=%b we=%b addr=%h din=%h busy=%b done=%b, required all 0",
                     fifo_rdeq, ram_we, ram_addr, ram_din, busy, done);
        end
        snap = wcount;
        repeat (4) @(negedge rvclk);
        rst_n = 1'b1;
        repeat (10) @(negedge rvclk);
        #1;
        checks++;
        if (wcount !== snap || wcount - base !== 8 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_nowrite: writes=%0d busy=%b, required 8/0", wcount - base, busy);
        end
        // Words 0..8 were consumed from the FIFO; top it up for a full transfer.
        load(32'h5000, 9);
        base = wcount;
        snap = done_cnt;
        pulse_start();
        wait_done(snap, ok);
        checks++;
        if (!ok || wcount - base !== 16) begin
            errors++;
            $display("FAIL midreset_restart_count: writes=%0d, required 16", wcount - base);
        end
        checks++;
        if (w_addr[base] !== 5'd0 || w_dat[base] !== 32'h4009 || w_addr[base+15] !== 5'd15 || w_dat[base+15] !== 32'h5008) begin
            errors++;
            $display("FAIL midreset_restart_data: first=%0d/%h last=%0d/%h, required 0/00004009 15/00005008",
                     w_addr[base], w_dat[base], w_addr[base+15], w_dat[base+15]);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (bad_rdeq !== 0) begin
            errors++;
            $display("FAIL rdeq_when_empty: %0d cycles, required 0", bad_rdeq);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_checksum();
        test_single();
        test_reset_mid();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
